store_buffer: RTL and testbench

- Write-side counterpart of the load/MEM-stage path: accepts store requests (SB/SH/SW) from the MEM stage and aligns write data into word lanes with per-byte enables.
- Queues stores in a small FIFO and drains them to data memory through a valid/ack write handshake.
- Raises a load-hazard flag when a pending store overlaps a load address, so the pipeline can stall the load until the store drains.

---
 rtl/riscv_pkg.sv | 28 ++
 rtl/sb_fifo.sv | 62 ++++++
 rtl/store_buffer.sv | 146 ++++++++++++++
 tb/tb_store_buffer.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared RV32 memory-path definitions: funct3 encodings, store-buffer entry
// layout and the byte-lane mask used by both the store and load paths.
package riscv_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam int unsigned WA_W = 30;

  typedef struct packed {
    logic [WA_W-1:0] word_addr;
    logic [3:0]      be;
    logic [31:0]     wdata;
  } sb_entry_t;

  // Byte lanes touched by an access of the given width at the given offset.
  function automatic logic [3:0] lane_mask(input logic [1:0] width, input logic [1:0] off);
    case (width)
      2'b00:   lane_mask = 4'b0001 << off;
      2'b01:   lane_mask = 4'b0011 << off;
      default: lane_mask = 4'b1111;
    endcase
  endfunction

endpackage

// File: rtl/sb_fifo.sv
// Circular buffer of store entries; exposes every slot and its valid bit so
// the owner can compare pending stores against an incoming load.
module sb_fifo
  import riscv_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push_i,
  input  sb_entry_t              push_data_i,
  input  logic                   pop_i,
  output sb_entry_t              head_o,
  output sb_entry_t              next_o,
  output sb_entry_t              entries_o [DEPTH],
  output logic [DEPTH-1:0]       valid_o,
  output logic [$clog2(DEPTH):0] count_o,
  output logic                   empty_o
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  sb_entry_t         mem_q [DEPTH];
  logic [PW-1:0]     rd_ptr_q, wr_ptr_q;
  logic [CW-1:0]     count_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop_i)  rd_ptr_q <= rd_ptr_q + PW'(1);
      case ({push_i, pop_i})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Payload storage needs no reset; validity is tracked by the pointers.
  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_ptr_q] <= push_data_i;
  end

  always_comb begin
    valid_o = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      valid_o[i] = {1'b0, PW'(PW'(i) - rd_ptr_q)} < count_q;
    end
  end

  assign head_o    = mem_q[rd_ptr_q];
  assign next_o    = mem_q[rd_ptr_q + PW'(1)];
  assign entries_o = mem_q;
  assign count_o   = count_q;
  assign empty_o   = (count_q == '0);

endmodule

// File: rtl/store_buffer.sv
// MEM-stage store buffer: lane-formats SB/SH/SW, queues them, drains to data
// memory over a valid/ack handshake and flags loads that overlap a pending store.
module store_buffer
  import riscv_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned AW    = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   st_valid,
  input  logic [2:0]             st_funct3,
  input  logic [AW-1:0]          st_addr,
  input  logic [31:0]            st_data,
  output logic                   st_ready,
  output logic                   st_err,
  input  logic [AW-1:0]          ld_addr,
  input  logic [2:0]             ld_funct3,
  output logic                   ld_hazard,
  output logic                   mem_we,
  output logic [AW-1:0]          mem_addr,
  output logic [31:0]            mem_wdata,
  output logic [3:0]             mem_be,
  input  logic                   mem_ack,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;
  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_WRITE = 1'b1;

  logic             legal, push, deq;
  sb_entry_t        push_entry, head, nxt;
  sb_entry_t        entries [DEPTH];
  logic [DEPTH-1:0] ent_valid;
  logic [3:0]       ld_mask;
  logic             unused_ld_sign;

  logic [0:0]       state_q, state_d;
  logic             mem_we_q, mem_we_d;
  sb_entry_t        bus_q, bus_d;
  logic             st_err_q, st_err_d;

  sb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .push_i      (push),
    .push_data_i (push_entry),
    .pop_i       (deq),
    .head_o      (head),
    .next_o      (nxt),
    .entries_o   (entries),
    .valid_o     (ent_valid),
    .count_o     (count),
    .empty_o     (empty)
  );

  // Legality and lane formatting of the incoming store.
  always_comb begin
    case (st_funct3)
      F3_B:    legal = 1'b1;
      F3_H:    legal = ~st_addr[0];
      F3_W:    legal = (st_addr[1:0] == 2'b00);
      default: legal = 1'b0;
    endcase
    push_entry.word_addr = WA_W'(st_addr[AW-1:2]);
    push_entry.be        = lane_mask(st_funct3[1:0], st_addr[1:0]);
    case (st_funct3[1:0])
      2'b00:   push_entry.wdata = {4{st_data[7:0]}};
      2'b01:   push_entry.wdata = {2{st_data[15:0]}};
      default: push_entry.wdata = st_data;
    endcase
  end

  assign deq      = mem_we_q & mem_ack;
  assign st_ready = (count != CW'(DEPTH)) | deq;
  assign push     = st_valid & st_ready & legal;
  assign st_err_d = st_valid & ~legal;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      mem_we_q <= 1'b0;
      bus_q    <= '0;
      st_err_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      mem_we_q <= mem_we_d;
      bus_q    <= bus_d;
      st_err_q <= st_err_d;
    end
  end

  // Drain: after an ack the next entry is either the second slot or the
  // store being enqueued this very cycle, so writes go back-to-back.
  always_comb begin
    state_d  = state_q;
    mem_we_d = mem_we_q;
    bus_d    = bus_q;
    case (state_q)
      S_IDLE: begin
        if (!empty) begin
          bus_d    = head;
          mem_we_d = 1'b1;
          state_d  = S_WRITE;
        end
      end
      S_WRITE: begin
        if (mem_ack) begin
          if ((count > CW'(1)) || push) begin
            bus_d = (count > CW'(1)) ? nxt : push_entry;
          end else begin
            mem_we_d = 1'b0;
            state_d  = S_IDLE;
          end
        end
      end
      default: begin
        mem_we_d = 1'b0;
        state_d  = S_IDLE;
      end
    endcase
  end

  // Any pending entry, including the one on the bus, that shares bytes with the load.
  always_comb begin
    ld_mask   = lane_mask(ld_funct3[1:0], ld_addr[1:0]);
    ld_hazard = 1'b0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (ent_valid[i] && (entries[i].word_addr == WA_W'(ld_addr[AW-1:2])) &&
          ((entries[i].be & ld_mask) != 4'b0000)) begin
        ld_hazard = 1'b1;
      end
    end
  end

  assign unused_ld_sign = ld_funct3[2];

  assign mem_we    = mem_we_q;
  assign mem_addr  = {(AW-2)'(bus_q.word_addr), 2'b00};
  assign mem_wdata = bus_q.wdata;
  assign mem_be    = bus_q.be;
  assign st_err    = st_err_q;

endmodule

// File: tb/tb_store_buffer.sv
// Directed bench for store_buffer: a queue-based reference model checked on
// every falling edge, plus literal expectations for each scenario.
module tb_store_buffer;

  localparam int DEPTH = 4;
  localparam int AW    = 32;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        st_valid = 1'b0;
  logic [2:0]  st_funct3 = 3'b000;
  logic [31:0] st_addr = '0;
  logic [31:0] st_data = '0;
  logic        st_ready, st_err;
  logic [31:0] ld_addr = '0;
  logic [2:0]  ld_funct3 = 3'b000;
  logic        ld_hazard;
  logic        mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_ack = 1'b0;
  logic        empty;
  logic [2:0]  count;

  store_buffer #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk(clk), .rst(rst),
    .st_valid(st_valid), .st_funct3(st_funct3), .st_addr(st_addr), .st_data(st_data),
    .st_ready(st_ready), .st_err(st_err),
    .ld_addr(ld_addr), .ld_funct3(ld_funct3), .ld_hazard(ld_hazard),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be),
    .mem_ack(mem_ack), .empty(empty), .count(count)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Reference model: list of pending stores, head is on the bus while busy.
  typedef struct packed {
    logic [31:0] byte_addr;
    logic [3:0]  be;
    logic [31:0] data;
  } ment_t;

  ment_t q[$];
  bit    busy  = 0;
  bit    err_m = 0;

  function automatic bit legal_m(input logic [2:0] f3, input logic [31:0] a);
    return (f3 == 3'd0) || (f3 == 3'd1 && a % 2 == 0) || (f3 == 3'd2 && a % 4 == 0);
  endfunction

  function automatic ment_t fmt(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
    ment_t e;
    int nb;
    int o;
    nb = (f3 == 3'd0) ? 1 : (f3 == 3'd1) ? 2 : 4;
    o  = int'(a % 4);
    e.byte_addr = a;
    e.be = 4'((((1 << nb) - 1) << o) & 15);
    if (nb == 1)      e.data = {d[7:0], d[7:0], d[7:0], d[7:0]};
    else if (nb == 2) e.data = {d[15:0], d[15:0]};
    else              e.data = d;
    return e;
  endfunction

  function automatic bit ready_m();
    return (q.size() != DEPTH) || (busy && mem_ack);
  endfunction

  // Overlap test done byte-by-byte within the load's word.
  function automatic bit hazard_m();
    int ln, lo, lend;
    ln   = (ld_funct3[1:0] == 2'd0) ? 1 : (ld_funct3[1:0] == 2'd1) ? 2 : 4;
    lo   = (ln == 4) ? 0 : int'(ld_addr % 4);
    lend = (lo + ln > 4) ? 4 : lo + ln;
    foreach (q[k]) begin
      if ((q[k].byte_addr / 4) == (ld_addr / 4)) begin
        for (int b = lo; b < lend; b++) if (q[k].be[b]) return 1'b1;
      end
    end
    return 1'b0;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      q.delete();
      busy  = 0;
      err_m = 0;
    end else begin
      bit pop, enq;
      int old;
      pop   = busy && mem_ack;
      enq   = st_valid && ready_m() && legal_m(st_funct3, st_addr);
      err_m = st_valid && !legal_m(st_funct3, st_addr);
      old   = q.size();
      if (pop) void'(q.pop_front());
      if (enq) q.push_back(fmt(st_funct3, st_addr, st_data));
      if (busy) busy = !mem_ack || (q.size() != 0);
      else      busy = (old != 0);
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      chk("mem_we", mem_we, busy);
      if (busy) begin
        chk("mem_addr", mem_addr, {q[0].byte_addr[31:2], 2'b00});
        chk("mem_be", mem_be, q[0].be);
        chk("mem_wdata", mem_wdata, q[0].data);
      end
      chk("count", count, q.size());
      chk("empty", empty, q.size() == 0);
      chk("st_ready", st_ready, ready_m());
      chk("st_err", st_err, err_m);
      chk("ld_hazard", ld_hazard, hazard_m());
    end
  end

  task automatic cyc(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drive_st(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
    st_valid  = 1'b1;
    st_funct3 = f3;
    st_addr   = a;
    st_data   = d;
  endtask

  initial begin
    cyc(2);
    chk("rst_mem_we", mem_we, 1'b0);
    chk("rst_count", count, 3'd0);
    chk("rst_empty", empty, 1'b1);
    chk("rst_st_err", st_err, 1'b0);
    chk("rst_bus", {mem_addr, mem_be}, 36'h0);
    chk("rst_wdata", mem_wdata, 32'h0);
    rst = 1'b0;
    cyc(1);

    // SB at an odd offset, ack held high
    mem_ack = 1'b1;
    drive_st(3'b000, 32'h1003, 32'hAABBCCDD);
    cyc(1);
    st_valid = 1'b0;
    cyc(1);
    chk("sb_we", mem_we, 1'b1);
    chk("sb_addr", mem_addr, 32'h1000);
    chk("sb_be", mem_be, 4'b1000);
    chk("sb_wdata", mem_wdata, 32'hDDDDDDDD);
    cyc(1);
    chk("sb_empty", empty, 1'b1);
    chk("sb_we_off", mem_we, 1'b0);

    // SH then SW, back-to-back drain
    drive_st(3'b001, 32'h2002, 32'h00001234);
    cyc(1);
    drive_st(3'b010, 32'h2004, 32'hCAFEF00D);
    cyc(1);
    st_valid = 1'b0;
    chk("sh_bus", {mem_we, mem_addr, mem_be}, {1'b1, 32'h2000, 4'b1100});
    chk("sh_wdata", mem_wdata, 32'h12341234);
    cyc(1);
    chk("sw_bus", {mem_we, mem_addr, mem_be}, {1'b1, 32'h2004, 4'b1111});
    chk("sw_wdata", mem_wdata, 32'hCAFEF00D);
    cyc(1);
    chk("b2b_idle", {mem_we, empty}, 2'b01);

    // Fill with ack low, then one ack lets the 5th store in
    mem_ack = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      drive_st(3'b010, 32'h5000 + 32'(4 * i), 32'h50000000 + 32'(i));
      cyc(1);
    end
    drive_st(3'b010, 32'h5010, 32'h50000004);
    cyc(2);
    chk("full_ready", st_ready, 1'b0);
    chk("full_count", count, 3'd4);
    chk("full_hold", mem_addr, 32'h5000);
    mem_ack = 1'b1;
    #1;
    chk("full_ready_ack", st_ready, 1'b1);
    cyc(1);
    st_valid = 1'b0;
    mem_ack  = 1'b0;
    chk("full_count_ack", count, 3'd4);
    chk("full_next", mem_addr, 32'h5004);
    cyc(1);
    mem_ack = 1'b1;
    cyc(5);
    chk("full_drained", empty, 1'b1);
    mem_ack = 1'b0;

    // Illegal stores
    drive_st(3'b001, 32'h3001, 32'h1);
    cyc(1);
    st_valid = 1'b0;
    chk("bad_sh_err", st_err, 1'b1);
    chk("bad_sh_count", count, 3'd0);
    cyc(1);
    chk("err_pulse", st_err, 1'b0);
    drive_st(3'b010, 32'h3002, 32'h2);
    cyc(1);
    st_valid = 1'b0;
    chk("bad_sw_err", st_err, 1'b1);
    cyc(1);
    drive_st(3'b011, 32'h3000, 32'h3);
    cyc(1);
    st_valid = 1'b0;
    chk("bad_f3_err", st_err, 1'b1);
    chk("bad_f3_state", {mem_we, count}, 4'b0000);
    cyc(1);

    // Load hazard against a pending SB
    drive_st(3'b000, 32'h4001, 32'h77);
    cyc(1);
    st_valid = 1'b0;
    cyc(1);
    ld_addr = 32'h4000; ld_funct3 = 3'b000; #1;
    chk("hz_lb", ld_hazard, 1'b0);
    ld_funct3 = 3'b001; #1;
    chk("hz_lh", ld_hazard, 1'b1);
    ld_addr = 32'h4004; ld_funct3 = 3'b010; #1;
    chk("hz_lw_other", ld_hazard, 1'b0);
    ld_addr = 32'h4000; ld_funct3 = 3'b001; mem_ack = 1'b1; #1;
    chk("hz_pop_cycle", ld_hazard, 1'b1);
    cyc(1);
    mem_ack = 1'b0;
    #1;
    chk("hz_after", ld_hazard, 1'b0);
    ld_addr = '0; ld_funct3 = 3'b000;
    cyc(1);

    // Reset in the middle of a write
    for (int i = 0; i < 3; i++) begin
      drive_st(3'b010, 32'h6000 + 32'(4 * i), 32'h60 + 32'(i));
      cyc(1);
    end
    st_valid = 1'b0;
    chk("pre_rst", {mem_we, count}, {1'b1, 3'd3});
    #2 rst = 1'b1;
    #1;
    chk("rst_async_we", mem_we, 1'b0);
    chk("rst_async_count", count, 3'd0);
    chk("rst_async_empty", empty, 1'b1);
    cyc(2);
    rst = 1'b0;
    mem_ack = 1'b1;
    cyc(5);
    chk("post_rst_idle", mem_we, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
